ads1675_serial_tx: RTL and testbench
====================================

// Module: ads1675_serial_tx
// PURPOSE
// - Transmit side of the ADS1675 serial output interface (sclk/dout/drdy), driven from aclk.
// - Accepts signed parallel samples over a valid/ready handshake and shifts each out MSB-first.
// - After the last bit it raises a drdy pulse, so a capture block latches the word on drdy rising.
// - Used as an ADC emulator for loopback, bring-up and bench stimulus of the collection system.
// PARAMETERS
// - DW       24  sample width in bits (>=2)
// - CLK_DIV  2   sclk half-period in aclk cycles (>=1); bit period = 2*CLK_DIV
// - DRDY_W   4   drdy high width in aclk cycles (>=1)
// - GAP_CYC  8   idle aclk cycles after drdy falls before s_ready reasserts (>=0)
// PORTS
// - aclk     in   1   system clock, single domain
// - areset   in   1   synchronous reset, active-high
// - en       in   1   global enable; low freezes all state and outputs
// - s_data   in   DW  signed sample to send
// - s_valid  in   1   s_data valid
// - s_ready  out  1   block idle, accepts a sample
// - sclk     out  1   serial shift clock, registered
// - dout     out  1   serial data, registered, MSB first
// - drdy     out  1   frame-complete strobe, registered, active-high
// - busy     out  1   high in any state other than IDLE
// BEHAVIOUR
// - Reset (areset=1 on an aclk edge): state IDLE, sclk=0, dout=0, drdy=0, busy=0, s_ready=1; counters cleared.
// - Reset has priority over en; reset mid-frame aborts the frame with no drdy pulse.
// - FSM states: IDLE -> SHIFT -> DRDY -> GAP -> IDLE. GAP is skipped when GAP_CYC=0.
// - IDLE:
//   - s_ready=1.
//   - On s_valid&&s_ready&&en at edge T: s_data captured into shift_reg, bit_cnt=DW-1, enter SHIFT.
//   - At T+1: sclk=1 and dout=s_data[DW-1].
// - SHIFT, per bit, 2*CLK_DIV cycles:
//   - sclk=1 for the first CLK_DIV cycles, sclk=0 for the next CLK_DIV.
//   - dout changes only on sclk rising, so it is stable at the sclk falling edge, where the receiver samples.
//   - After bit 0 completes its low half, enter DRDY with sclk=0.
//   - dout holds bit 0 until the next frame, or until reset.
// - DRDY:
//   - drdy=1 for exactly DRDY_W cycles.
//   - drdy rises at T+1+DW*2*CLK_DIV (DW=24, CLK_DIV=2: T+97).
//   - Then GAP for GAP_CYC cycles with drdy=0 and s_ready=0.
// - Frame period = 1 + DW*2*CLK_DIV + DRDY_W + GAP_CYC cycles, counted accept edge to accept edge with s_valid held.
// - s_valid while busy is ignored; there is no queueing, and the upstream holds data until s_ready.
// - en=0: div, bit and drdy counters and FSM hold; sclk, dout and drdy hold their current levels; s_ready forced 0.
// - Counter widths: $clog2(CLK_DIV), $clog2(DW), $clog2(DRDY_W+1), $clog2(GAP_CYC+1); min width 1.
//   - No wrap: each counter reloads on state entry.
// - No combinational path from any input to sclk, dout or drdy.
// STRUCTURE
// - ads1675_pkg: typedef enum logic [1:0] {IDLE,SHIFT,DRDY,GAP} tx_state_t.
// - ads1675_pkg: localparam default DW=24 and the sample-code constants FS_POS=24'h7FFFFF and FS_NEG=24'h800000.
// - Sub-module sclk_div: CLK_DIV counter producing rise_tick and fall_tick.
//   - Inputs: clear, en.
//   - The top FSM consumes the ticks; shift register and FSM live in the top.
// TESTING
// 1. DW=24, CLK_DIV=2, send 24'hA5F00F at T -> 24 sclk falls; sampled bits 1010_0101_1111_0000_0000_1111.
//    - drdy rises at T+97 and is high for 4 cycles; s_ready back at T+109.
// 2. s_valid held with alternating FS_POS/FS_NEG -> one accept per 109 cycles.
//    - A loopback receiver, shifting on sclk falling and latching on drdy rising, reads 7FFFFF then 800000, no loss.
// 3. areset=1 at T+40 mid-SHIFT -> next edge: sclk=0, dout=0, drdy=0, s_ready=1; no drdy pulse for that frame.
// 4. en=0 for 10 cycles during SHIFT -> sclk/dout frozen; drdy rise delayed by exactly 10 cycles; word intact.
// 5. s_valid pulsed during SHIFT/DRDY/GAP -> not accepted; s_ready stays 0; the in-flight word is unchanged.
// 6. CLK_DIV=1, DRDY_W=1, GAP_CYC=0 -> sclk = aclk/2; drdy at T+49 for 1 cycle; next accept at T+50.

Source files
------------

// File: rtl/ads1675_pkg.sv
// +--------------------------------------------------------------------+
// | ads1675_pkg : shared FSM states and sample-code constants          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package ads1675_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRDY  = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam int          DEFAULT_DW = 24;
  localparam logic [23:0] FS_POS     = 24'h7FFFFF;
  localparam logic [23:0] FS_NEG     = 24'h800000;

endpackage

`default_nettype wire

// File: rtl/ads1675_serial_tx_sclk_div.sv
// +--------------------------------------------------------------------+
// | sclk_div : half-period counter emitting sclk fall/rise ticks       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int             CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             low_q, low_d;
  logic             w_tick;

  // low_q tracks which half of the bit period is running (0 = sclk high)
  assign w_tick      = en_i && !clear_i && (cnt_q == CNT_LAST);
  assign fall_tick_o = w_tick && !low_q;
  assign rise_tick_o = w_tick && low_q;

  always_comb begin
    cnt_d = cnt_q;
    low_d = low_q;
    if (clear_i) begin
      cnt_d = '0;
      low_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        low_d = !low_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      low_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ads1675_serial_tx.sv
// +--------------------------------------------------------------------+
// | ads1675_serial_tx : ADS1675-style sclk/dout/drdy serial emitter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ads1675_serial_tx
  import ads1675_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int CLK_DIV = 2,
  parameter int DRDY_W  = 4,
  parameter int GAP_CYC = 8
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          sclk,
  output logic          dout,
  output logic          drdy,
  output logic          busy
);

  localparam int BIT_W  = (DW > 1) ? $clog2(DW) : 1;
  localparam int DRDY_CW = (DRDY_W > 0) ? $clog2(DRDY_W + 1) : 1;
  localparam int GAP_CW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [DRDY_CW-1:0] DRDY_LAST = DRDY_CW'(DRDY_W - 1);
  localparam logic [GAP_CW-1:0]  GAP_LAST  = GAP_CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  tx_state_t          state_q, state_d;
  logic [DW-2:0]      shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DRDY_CW-1:0] drdy_cnt_q, drdy_cnt_d;
  logic [GAP_CW-1:0]  gap_q, gap_d;
  logic               sclk_q, sclk_d;
  logic               dout_q, dout_d;
  logic               drdy_q, drdy_d;
  logic               w_rise, w_fall;

  sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk_i       (aclk),
    .rst_i       (areset),
    .clear_i     (state_q != SHIFT),
    .en_i        (en),
    .rise_tick_o (w_rise),
    .fall_tick_o (w_fall)
  );

  assign s_ready = en && (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign sclk    = sclk_q;
  assign dout    = dout_q;
  assign drdy    = drdy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    drdy_cnt_d = drdy_cnt_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    dout_d     = dout_q;
    drdy_d     = drdy_q;
    unique case (state_q)
      IDLE: begin
        // MSB goes straight to dout; shift_q keeps only the remaining bits
        if (s_valid && s_ready) begin
          state_d = SHIFT;
          shift_d = s_data[DW-2:0];
          bit_d   = BIT_W'(DW - 1);
          sclk_d  = 1'b1;
          dout_d  = s_data[DW-1];
        end
      end
      SHIFT: begin
        if (w_fall) begin
          sclk_d = 1'b0;
        end else if (w_rise) begin
          if (bit_q == '0) begin
            state_d    = DRDY;
            drdy_d     = 1'b1;
            drdy_cnt_d = '0;
          end else begin
            sclk_d  = 1'b1;
            dout_d  = shift_q[DW-2];
            shift_d = shift_q << 1;
            bit_d   = bit_q - 1'b1;
          end
        end
      end
      DRDY: begin
        if (drdy_cnt_q == DRDY_LAST) begin
          drdy_d  = 1'b0;
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end else begin
          drdy_cnt_d = drdy_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // en low freezes every register, so outputs hold their levels
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      drdy_cnt_q <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      dout_q     <= 1'b0;
      drdy_q     <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      drdy_cnt_q <= drdy_cnt_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      dout_q     <= dout_d;
      drdy_q     <= drdy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ads1675_serial_tx.sv
// +--------------------------------------------------------------------+
// | tb_ads1675_serial_tx : frame-position model plus loopback receiver |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ads1675_serial_tx;
  import ads1675_pkg::*;

  localparam int DW = 24;

  logic          aclk;
  logic          areset;
  logic [1:0]    en;
  logic [DW-1:0] s_data [2];
  logic [1:0]    s_valid;
  logic [1:0]    s_ready, sclk, dout, drdy, busy;

  // dut: default timing; dut_fast: CLK_DIV=1, DRDY_W=1, GAP_CYC=0
  ads1675_serial_tx #(.DW(DW), .CLK_DIV(2), .DRDY_W(4), .GAP_CYC(8)) dut (
    .aclk(aclk), .areset(areset), .en(en[0]), .s_data(s_data[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .sclk(sclk[0]),
    .dout(dout[0]), .drdy(drdy[0]), .busy(busy[0]));

  ads1675_serial_tx #(.DW(DW), .CLK_DIV(1), .DRDY_W(1), .GAP_CYC(0)) dut_fast (
    .aclk(aclk), .areset(areset), .en(en[1]), .s_data(s_data[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .sclk(sclk[1]),
    .dout(dout[1]), .drdy(drdy[1]), .busy(busy[1]));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int cdiv(int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int drdyw(int d); return (d == 0) ? 4 : 1; endfunction
  function automatic int gapc(int d);  return (d == 0) ? 8 : 0; endfunction
  function automatic int flen(int d);  return DW * 2 * cdiv(d) + drdyw(d) + gapc(d); endfunction

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_on = 0;

  // model: k = enabled edges elapsed since the accept edge
  bit            active    [2];
  int            k         [2];
  logic [DW-1:0] word      [2];
  bit            dout_idle [2];
  int            n_acc     [2];
  int            acc_edge  [2];
  int            prev_acc  [2];

  // loopback receiver and edge timestamps (edge index at which a level is sampled)
  bit            p_sclk [2], p_drdy [2], p_rdy [2];
  logic [DW-1:0] rx     [2];
  int            falls  [2], n_rise [2];
  int            rise_e [2], fall_e [2], rdy_e [2];
  logic [DW-1:0] cap0 [$];
  logic [DW-1:0] cap1 [$];

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, d, cyc + 1, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (areset) begin
          active[d]    = 0;
          dout_idle[d] = 0;
        end else if (en[d]) begin
          if (active[d]) begin
            if (k[d] == flen(d) - 1) begin
              active[d]    = 0;
              dout_idle[d] = word[d][0];
            end else begin
              k[d]++;
            end
          end else if (s_valid[d]) begin
            active[d]   = 1;
            k[d]        = 0;
            word[d]     = s_data[d];
            prev_acc[d] = acc_edge[d];
            acc_edge[d] = cyc;
            n_acc[d]++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      if (chk_on) begin
        for (int d = 0; d < 2; d++) begin : cmp
          logic es, ed, edr, eb, er;
          int   p, sh;
          p   = 2 * cdiv(d);
          sh  = DW * p;
          es  = 1'b0;
          ed  = dout_idle[d];
          edr = 1'b0;
          eb  = 1'b0;
          er  = en[d];
          if (active[d]) begin
            eb = 1'b1;
            er = 1'b0;
            ed = word[d][0];
            if (k[d] < sh) begin
              es = ((k[d] % p) < cdiv(d));
              ed = word[d][DW - 1 - k[d] / p];
            end else if (k[d] < sh + drdyw(d)) begin
              edr = 1'b1;
            end
          end
          chk("sclk", d, 32'(sclk[d]), 32'(es));
          chk("dout", d, 32'(dout[d]), 32'(ed));
          chk("drdy", d, 32'(drdy[d]), 32'(edr));
          chk("busy", d, 32'(busy[d]), 32'(eb));
          chk("s_ready", d, 32'(s_ready[d]), 32'(er));

          if (p_sclk[d] && !sclk[d]) begin
            rx[d] = {rx[d][DW-2:0], dout[d]};
            falls[d]++;
          end
          if (drdy[d] && !p_drdy[d]) begin
            if (d == 0) cap0.push_back(rx[d]);
            else        cap1.push_back(rx[d]);
            rise_e[d] = cyc + 1;
            n_rise[d]++;
          end
          if (!drdy[d] && p_drdy[d]) fall_e[d] = cyc + 1;
          if (s_ready[d] && !p_rdy[d]) rdy_e[d] = cyc + 1;
          p_sclk[d] = sclk[d];
          p_drdy[d] = drdy[d];
          p_rdy[d]  = s_ready[d];
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_acc(input int d, input int bound);
    int n0;
    n0 = n_acc[d];
    for (int i = 0; i < bound; i++) begin
      step();
      if (n_acc[d] != n0) break;
    end
    chk("accept_timeout", d, 32'(n_acc[d] != n0), 32'd1);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 300; i++) begin
      if (!busy[d]) break;
      step();
    end
    chk("idle_timeout", d, 32'(busy[d]), 32'd0);
  endtask

  task automatic chk_cap(input int d, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    int sz;
    sz = (d == 0) ? cap0.size() : cap1.size();
    if (sz == 0) begin
      chk("capture_missing", d, 32'd0, 32'd1);
    end else begin
      got = (d == 0) ? cap0.pop_front() : cap1.pop_front();
      chk("capture_word", d, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    int base, pos, rises;
    int offs [3];
    areset     = 1'b1;
    en         = 2'b11;
    s_valid    = 2'b00;
    s_data[0]  = '0;
    s_data[1]  = '0;
    step();
    chk_on = 1;
    step();
    areset = 1'b0;

    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_sclk", d, 32'(sclk[d]), 32'd0);
      chk("rst_dout", d, 32'(dout[d]), 32'd0);
      chk("rst_drdy", d, 32'(drdy[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_ready", d, 32'(s_ready[d]), 32'd1);
    end

    // single frame, literal timing
    falls[0]  = 0;
    s_data[0] = 24'hA5F00F;
    s_valid[0] = 1'b1;
    wait_acc(0, 10);
    s_valid[0] = 1'b0;
    chk("first_sclk", 0, 32'(sclk[0]), 32'd1);
    chk("first_dout", 0, 32'(dout[0]), 32'd1);
    wait_idle(0);
    step();
    chk("drdy_rise_ofs", 0, 32'(rise_e[0] - acc_edge[0]), 32'd97);
    chk("drdy_width", 0, 32'(fall_e[0] - rise_e[0]), 32'd4);
    chk("ready_back_ofs", 0, 32'(rdy_e[0] - acc_edge[0]), 32'd109);
    chk("sclk_falls", 0, 32'(falls[0]), 32'd24);
    chk_cap(0, 24'hA5F00F);

    // back-to-back full-scale codes with s_valid held
    s_data[0]  = FS_POS;
    s_valid[0] = 1'b1;
    wait_acc(0, 10);
    s_data[0]  = FS_NEG;
    wait_acc(0, 200);
    s_valid[0] = 1'b0;
    chk("accept_period", 0, 32'(acc_edge[0] - prev_acc[0]), 32'd109);
    wait_idle(0);
    step();
    chk_cap(0, FS_POS);
    chk_cap(0, FS_NEG);

    // reset mid-SHIFT aborts the frame
    rises      = n_rise[0];
    s_data[0]  = 24'h123456;
    s_valid[0] = 1'b1;
    wait_acc(0, 10);
    s_valid[0] = 1'b0;
    repeat (39) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("abort_sclk", 0, 32'(sclk[0]), 32'd0);
    chk("abort_dout", 0, 32'(dout[0]), 32'd0);
    chk("abort_drdy", 0, 32'(drdy[0]), 32'd0);
    chk("abort_ready", 0, 32'(s_ready[0]), 32'd1);
    repeat (120) step();
    chk("abort_no_drdy", 0, 32'(n_rise[0]), 32'(rises));

    // en low for 10 cycles mid-SHIFT
    s_data[0]  = 24'h3C5A96;
    s_valid[0] = 1'b1;
    wait_acc(0, 10);
    s_valid[0] = 1'b0;
    repeat (20) step();
    en[0] = 1'b0;
    repeat (10) step();
    en[0] = 1'b1;
    wait_idle(0);
    step();
    chk("stall_drdy_ofs", 0, 32'(rise_e[0] - acc_edge[0]), 32'd107);
    chk_cap(0, 24'h3C5A96);

    // s_valid pulses during SHIFT, DRDY and GAP are ignored
    s_data[0]  = 24'h5AC3E1;
    s_valid[0] = 1'b1;
    wait_acc(0, 10);
    s_valid[0] = 1'b0;
    base = n_acc[0];
    offs = '{30, 98, 104};
    pos  = 0;
    for (int i = 0; i < 3; i++) begin
      while (pos < offs[i] - 1) begin
        step();
        pos++;
      end
      s_data[0]  = 24'hFFFFFF;
      s_valid[0] = 1'b1;
      step();
      pos++;
      s_valid[0] = 1'b0;
    end
    wait_idle(0);
    step();
    chk("busy_no_accept", 0, 32'(n_acc[0]), 32'(base));
    chk_cap(0, 24'h5AC3E1);

    // fast configuration
    s_data[1]  = 24'h96C3A5;
    s_valid[1] = 1'b1;
    wait_acc(1, 10);
    s_data[1]  = 24'h0F0F0F;
    wait_acc(1, 100);
    s_valid[1] = 1'b0;
    chk("fast_period", 1, 32'(acc_edge[1] - prev_acc[1]), 32'd50);
    chk("fast_drdy_ofs", 1, 32'(rise_e[1] - prev_acc[1]), 32'd49);
    chk("fast_drdy_width", 1, 32'(fall_e[1] - rise_e[1]), 32'd1);
    wait_idle(1);
    step();
    chk_cap(1, 24'h96C3A5);
    chk_cap(1, 24'h0F0F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
